pipeline_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage MIPS pipeline. It generates the write-enable, flush and bubble controls for the PC, the IF/ID and ID/EX pipeline registers, and the later-stage registers. Causes handled: load-use hazards, taken branches/jumps, instruction/data memory wait states and multi-cycle MULT/DIV occupancy. It also keeps stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 9 +
 rtl/pipeline_hazard_ctrl_muldiv_busy_timer.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encoding, constants and the RAW-hazard helper for the hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP      = 32'd0;
    function automatic logic raw_hit(input logic [4:0] src, input logic [4:0] dst);
        return (dst != REG_ZERO) && (dst == src);
    endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_busy_timer.sv
// muldiv_busy_timer: 8-bit down-counter that holds the HI/LO unit busy for LATENCY cycles after a start.
module muldiv_busy_timer #(
    parameter int LATENCY = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    output logic busy
);
    logic [7:0] md_cnt_q, md_cnt_d;
    always_comb md_cnt_d = start ? 8'(LATENCY) : (md_cnt_q != 8'd0 ? md_cnt_q - 8'd1 : md_cnt_q);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) md_cnt_q <= 8'd0;
        else          md_cnt_q <= md_cnt_d;
    end
    assign busy = md_cnt_q != 8'd0;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: prioritised stall/flush/bubble control for the 5-stage pipeline,
// plus saturating stall and flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             back_write,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             load_use, hilo_haz, flush_evt;
    logic [4:0]       ctrl;

    muldiv_busy_timer #(.LATENCY(MULDIV_LATENCY)) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (muldiv_start && dmem_ready),
        .busy   (muldiv_busy)
    );

    assign load_use  = ex_mem_read && (raw_hit(id_rs, ex_rt) || (id_uses_rt && raw_hit(id_rt, ex_rt)));
    assign hilo_haz  = id_uses_hilo && muldiv_busy;
    assign flush_evt = reset_n && dmem_ready && branch_taken;

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && !dmem_ready) state_d = MEM_WAIT;
        if (state_q == MEM_WAIT && dmem_ready) state_d = RUN;
        // ctrl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, back_write}
        ctrl = !reset_n              ? 5'b00110 :
               !dmem_ready           ? 5'b00000 :
               branch_taken          ? 5'b11111 :
               (load_use || hilo_haz) ? 5'b00011 :
               !imem_ready           ? 5'b01101 : 5'b11001;
        stall_d = (!ctrl[4] && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush_evt && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    end

    assign {pc_write, if_id_write, if_id_flush, id_ex_bubble, back_write} = ctrl;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end
endmodule
